// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter in front of a single fixed-latency memory.
//   Port 0 is the CPU, port 1 is the debug port. One transaction is in flight
//   at a time: IDLE (accept) -> ACCESS (MEM_LAT cycles) -> DONE (1 cycle).
//
// Parameters
//   ADDR_W   address width of memory and both ports
//   DATA_W   data width of memory and both ports
//   MEM_LAT  memory access cycles per transaction, legal range 1..15
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request; req held until cpu_done
//   dbg_req/we/addr/wdata      debug request; req held until dbg_done
//   cpu_gnt, dbg_gnt           port owns memory (ACCESS and DONE)
//   cpu_done, dbg_done         one-cycle completion pulse
//   rdata                      read data of the last completed read
//   cpu_stall                  cpu_req & ~cpu_done
//   mem_en, mem_we             memory enable / write strobe (ACCESS only)
//   mem_addr, mem_wdata        latched command to memory
//   mem_rdata                  memory read data, valid on last ACCESS cycle
//   fsm_state                  debug view of the FSM (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake: a port raises req with we/addr/wdata stable and keeps req high
// until its done pulse; the command is sampled once, on the IDLE cycle that
// accepts it, so later changes on the port have no effect. A req still high
// in IDLE after DONE counts as a new request.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_done,
  output logic              dbg_done,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          cnt_q;
  logic                last_q;   // 1: dbg served last, so cpu wins a tie
  logic                owner_q;  // 0: cpu, 1: dbg
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic any_req;
  logic pick_dbg;

  assign any_req  = cpu_req | dbg_req;
  // dbg wins when it is alone, or on a tie when cpu was served last.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command latch, latency counter, round-robin pointer and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= pick_dbg;
            last_q  <= pick_dbg;
            we_q    <= pick_dbg ? dbg_we    : cpu_we;
            addr_q  <= pick_dbg ? dbg_addr  : cpu_addr;
            wdata_q <= pick_dbg ? dbg_wdata : cpu_wdata;
            cnt_q   <= LAT_M1;
          end
        end
        S_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!we_q) begin
            // Final ACCESS cycle of a read: memory data is valid now.
            rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. Control outputs are forced low while rst is high so that the
  // reset cycle itself is quiet, even before the first reset edge.
  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    cpu_done = 1'b0;
    dbg_done = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if (!rst) begin
      if (state_q == S_ACCESS || state_q == S_DONE) begin
        cpu_gnt = ~owner_q;
        dbg_gnt = owner_q;
      end
      if (state_q == S_DONE) begin
        cpu_done = ~owner_q;
        dbg_done = owner_q;
      end
      if (state_q == S_ACCESS) begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u_dut runs with MEM_LAT=2, u_dut1 with
//   MEM_LAT=1. Inputs are driven 1 ns after the rising edge and outputs are
//   checked 1 ns later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            checks = 0;
  int            failures = 0;

  // MEM_LAT=2 instance
  logic          cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0, mem_rdata = '0;
  logic          cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_stall, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    fsm_state;

  // MEM_LAT=1 instance
  logic          c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [AW-1:0] c1_addr = '0, d1_addr = '0;
  logic [DW-1:0] c1_wdata = '0, d1_wdata = '0, m1_rdata = '0;
  logic          c1_gnt, d1_gnt, c1_done, d1_done, c1_stall, m1_en, m1_we;
  logic [DW-1:0] r1_data, m1_wdata;
  logic [AW-1:0] m1_addr;
  logic [1:0]    f1_state;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_done(cpu_done), .dbg_done(dbg_done),
    .rdata(rdata), .cpu_stall(cpu_stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .cpu_gnt(c1_gnt), .dbg_gnt(d1_gnt), .cpu_done(c1_done), .dbg_done(d1_done),
    .rdata(r1_data), .cpu_stall(c1_stall), .mem_en(m1_en), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
    .fsm_state(f1_state)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cpu_req = 0; dbg_req = 0; c1_req = 0; d1_req = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; cpu_req = 1;
    step(); step(); #1;
    checks++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt: got %b%b expected 00", cpu_gnt, dbg_gnt); end
    checks++; if (cpu_done !== 1'b0 || dbg_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b%b expected 00", cpu_done, dbg_done); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem: got en=%b we=%b expected 0 0", mem_en, mem_we); end
    checks++; if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected 0", rdata, mem_addr, mem_wdata); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_hi: got %b expected 1", cpu_stall); end
    cpu_req = 0; #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_lo: got %b expected 0", cpu_stall); end
    rst = 0;
  endtask

  task automatic test_cpu_read();
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF; #1;
    checks++; if (cpu_stall !== 1'b1 || mem_en !== 1'b0 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL rd_accept: got stall=%b en=%b gnt=%b expected 1 0 0", cpu_stall, mem_en, cpu_gnt); end
    step(); #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin failures++; $display("FAIL rd_acc1: got en=%b we=%b addr=%h expected 1 0 10", mem_en, mem_we, mem_addr); end
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || cpu_done !== 1'b0) begin failures++; $display("FAIL rd_acc1_gnt: got gnt=%b%b done=%b expected 10 0", cpu_gnt, dbg_gnt, cpu_done); end
    // Port changes after acceptance must not leak into the transaction.
    cpu_addr = 32'h99; cpu_we = 1;
    step(); #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || cpu_done !== 1'b0) begin failures++; $display("FAIL rd_acc2: got en=%b we=%b addr=%h done=%b expected 1 0 10 0", mem_en, mem_we, mem_addr, cpu_done); end
    step(); #1;
    checks++; if (cpu_done !== 1'b1 || mem_en !== 1'b0 || cpu_gnt !== 1'b1) begin failures++; $display("FAIL rd_done: got done=%b en=%b gnt=%b expected 1 0 1", cpu_done, mem_en, cpu_gnt); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", rdata); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rd_stall: got %b expected 0", cpu_stall); end
    cpu_req = 0; cpu_we = 0;
    step(); #1;
    checks++; if (cpu_done !== 1'b0 || cpu_gnt !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL rd_idle: got done=%b gnt=%b state=%0d expected 0 0 0", cpu_done, cpu_gnt, fsm_state); end
  endtask

  task automatic test_dbg_write();
    step();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    for (int c = 1; c <= 2; c++) begin
      step(); #1;
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_acc%0d: got en=%b we=%b addr=%h wdata=%h expected 1 1 20 12345678", c, mem_en, mem_we, mem_addr, mem_wdata); end
      checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt%0d: got cpu=%b dbg=%b expected 0 1", c, cpu_gnt, dbg_gnt); end
    end
    step(); #1;
    checks++; if (dbg_done !== 1'b1 || cpu_done !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL wr_done: got dbg=%b cpu=%b we=%b en=%b expected 1 0 0 0", dbg_done, cpu_done, mem_we, mem_en); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rdata: got %h expected deadbeef", rdata); end
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_hold: got addr=%h wdata=%h expected 20 12345678", mem_addr, mem_wdata); end
    dbg_req = 0; dbg_we = 0;
    step();
  endtask

  task automatic test_tie();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
    step(); #1;
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_addr !== 32'h100) begin failures++; $display("FAIL tie1_gnt: got cpu=%b dbg=%b addr=%h expected 1 0 100", cpu_gnt, dbg_gnt, mem_addr); end
    step(); step(); #1;
    checks++; if (cpu_done !== 1'b1) begin failures++; $display("FAIL tie1_done: got %b expected 1", cpu_done); end
    cpu_req = 0;
    step(); #1;
    checks++; if (fsm_state !== 2'd0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL tie_idle: got state=%0d gnt=%b%b expected 0 00", fsm_state, cpu_gnt, dbg_gnt); end
    step(); #1;
    checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 32'h200) begin failures++; $display("FAIL tie2_gnt: got cpu=%b dbg=%b addr=%h expected 0 1 200", cpu_gnt, dbg_gnt, mem_addr); end
    step(); step(); #1;
    checks++; if (dbg_done !== 1'b1) begin failures++; $display("FAIL tie2_done: got %b expected 1", dbg_done); end
    cpu_req = 1;
    step(); step(); #1;
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL tie3_gnt: got cpu=%b dbg=%b expected 1 0", cpu_gnt, dbg_gnt); end
    step(); step();
    cpu_req = 0; dbg_req = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int n_cpu = 0;
    int n_dbg = 0;
    do_reset();
    cpu_req = 1; dbg_req = 1;
    // Expected 8-cycle pattern: I, A(cpu), A(cpu), D(cpu), I, A(dbg), A(dbg), D(dbg)
    for (int k = 0; k < 24; k++) begin
      int ph;
      ph = k % 8;
      #1;
      checks++; if (cpu_gnt !== (ph >= 1 && ph <= 3) || dbg_gnt !== (ph >= 5)) begin failures++; $display("FAIL b2b_gnt k=%0d: got cpu=%b dbg=%b expected %b %b", k, cpu_gnt, dbg_gnt, (ph >= 1 && ph <= 3), (ph >= 5)); end
      checks++; if (cpu_done !== (ph == 3) || dbg_done !== (ph == 7)) begin failures++; $display("FAIL b2b_done k=%0d: got cpu=%b dbg=%b expected %b %b", k, cpu_done, dbg_done, (ph == 3), (ph == 7)); end
      if (cpu_done === 1'b1) n_cpu++;
      if (dbg_done === 1'b1) n_dbg++;
      step();
    end
    checks++; if (n_cpu != 3 || n_dbg != 3) begin failures++; $display("FAIL b2b_count: got cpu=%0d dbg=%0d expected 3 3", n_cpu, n_dbg); end
    cpu_req = 0; dbg_req = 0;
    step(); step(); step(); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    step(); step(); step(); // now in DONE
    cpu_req = 0;
    step();                 // IDLE, pointer now says cpu served last
    cpu_req = 1;
    step(); step(); #1;     // second ACCESS cycle
    checks++; if (mem_en !== 1'b1 || cpu_gnt !== 1'b1) begin failures++; $display("FAIL rm_acc2: got en=%b gnt=%b expected 1 1", mem_en, cpu_gnt); end
    rst = 1; cpu_req = 0; #1;
    checks++; if (mem_en !== 1'b0 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL rm_during: got en=%b gnt=%b expected 0 0", mem_en, cpu_gnt); end
    step();
    rst = 0; #1;
    checks++; if (mem_en !== 1'b0 || cpu_done !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL rm_after: got en=%b done=%b state=%0d expected 0 0 0", mem_en, cpu_done, fsm_state); end
    step(); #1;
    checks++; if (mem_en !== 1'b0 || cpu_done !== 1'b0) begin failures++; $display("FAIL rm_quiet: got en=%b done=%b expected 0 0", mem_en, cpu_done); end
    cpu_req = 1; dbg_req = 1;
    step(); #1;
    checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin failures++; $display("FAIL rm_ptr: got cpu=%b dbg=%b expected 1 0", cpu_gnt, dbg_gnt); end
    step(); step();
    cpu_req = 0; dbg_req = 0;
    step();
  endtask

  task automatic test_lat1();
    c1_req = 1; c1_we = 0; c1_addr = 32'h44; m1_rdata = 32'h0BADF00D;
    step(); #1;
    checks++; if (m1_en !== 1'b1 || c1_gnt !== 1'b1 || c1_done !== 1'b0 || m1_addr !== 32'h44) begin failures++; $display("FAIL l1_acc: got en=%b gnt=%b done=%b addr=%h expected 1 1 0 44", m1_en, c1_gnt, c1_done, m1_addr); end
    step(); #1;
    checks++; if (c1_done !== 1'b1 || m1_en !== 1'b0 || r1_data !== 32'h0BADF00D) begin failures++; $display("FAIL l1_done: got done=%b en=%b rdata=%h expected 1 0 0badf00d", c1_done, m1_en, r1_data); end
    c1_req = 0;
    step(); #1;
    checks++; if (c1_done !== 1'b0 || f1_state !== 2'd0) begin failures++; $display("FAIL l1_idle: got done=%b state=%0d expected 0 0", c1_done, f1_state); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
